ir_queue: RTL

Parameterised instruction register with an integrated prefetch queue for the multicycle MIPS core. It sits between instruction memory and the control unit/register file. Fetched words, each tagged with its PC, are buffered in a DEPTH-entry FIFO. On IR_Write the oldest word is loaded into the architectural IR, whose decoded fields stay stable until the next IR_Write. A flush input discards all buffered and current instructions on a taken branch or jump.

---
 rtl/mips_ir_pkg.sv | 52 +++++
 rtl/ir_queue_fifo.sv | 52 +++++
 rtl/ir_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/mips_ir_pkg.sv
// mips_ir_pkg: shared definitions for the MIPS instruction register slice.
//   - bit positions of every decoded instruction field
//   - ins_t instruction word type and NOP_INS constant
//   - ir_fields_t decoded field bundle plus decode() helper
package mips_ir_pkg;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned SH_HI  = 10;
  localparam int unsigned SH_LO  = 6;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned ABS_HI = 25;
  localparam int unsigned ABS_LO = 0;

  typedef logic [31:0] ins_t;

  localparam ins_t NOP_INS = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] imm_abs;
  } ir_fields_t;

  function automatic ir_fields_t decode(input ins_t w);
    ir_fields_t f;
    f.op      = w[OP_HI:OP_LO];
    f.rs      = w[RS_HI:RS_LO];
    f.rt      = w[RT_HI:RT_LO];
    f.rd      = w[RD_HI:RD_LO];
    f.shamt   = w[SH_HI:SH_LO];
    f.func    = w[FN_HI:FN_LO];
    f.imm     = w[IMM_HI:IMM_LO];
    f.imm_abs = w[ABS_HI:ABS_LO];
    return f;
  endfunction

endpackage

// File: rtl/ir_queue_fifo.sv
// ir_queue_fifo: DEPTH-entry FIFO storage with head/tail pointers and count.
//   clk, rst   : clock, async active-high reset
//   push, pop  : enqueue din / dequeue head (caller guarantees legality)
//   clear      : synchronous empty, overrides push/pop
//   din, dout  : write data / head-of-queue data
//   count      : occupancy 0..DEPTH
module ir_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= din;
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign dout = mem[head];

endmodule

// File: rtl/ir_queue.sv
// ir_queue: instruction register fed by a prefetch FIFO of PC-tagged words.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ins/in_pc, in_ready : fetch-side handshake
//   IR_Write            : advance IR to the next instruction
//   flush               : discard queue and IR (highest priority)
//   ir_valid, ir_pc     : IR status and PC tag
//   OpCode..Imm_abs     : fields sliced from the registered IR word
//   count               : FIFO occupancy (IR not included)
module ir_queue
  import mips_ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [31:0]             in_ins,
  input  logic [PC_W-1:0]         in_pc,
  output logic                    in_ready,
  input  logic                    IR_Write,
  input  logic                    flush,
  output logic                    ir_valid,
  output logic [PC_W-1:0]         ir_pc,
  output logic [5:0]              OpCode,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [4:0]              shamt,
  output logic [5:0]              func,
  output logic [15:0]             Imm,
  output logic [25:0]             Imm_abs,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned W     = 32 + PC_W;

  ins_t            ir_word;
  ir_fields_t      f;
  logic [W-1:0]    head_data;
  ins_t            head_ins;
  logic [PC_W-1:0] head_pc;
  logic            empty, full, pop, push, bypass;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = IR_Write && !flush && !empty;
  assign bypass = IR_Write && !flush && empty && in_valid;
  assign in_ready = !full || pop;
  assign push   = in_valid && in_ready && !flush && !bypass;

  assign {head_ins, head_pc} = head_data;

  ir_queue_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   ({in_ins, in_pc}),
    .dout  (head_data),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_word  <= NOP_INS;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_word  <= NOP_INS;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (IR_Write) begin
      if (pop) begin
        ir_word  <= head_ins;
        ir_pc    <= head_pc;
        ir_valid <= 1'b1;
      end else if (bypass) begin
        ir_word  <= in_ins;
        ir_pc    <= in_pc;
        ir_valid <= 1'b1;
      end else begin
        ir_word  <= NOP_INS;
        ir_pc    <= '0;
        ir_valid <= 1'b0;
      end
    end
  end

  assign f       = decode(ir_word);
  assign OpCode  = f.op;
  assign rs      = f.rs;
  assign rt      = f.rt;
  assign rd      = f.rd;
  assign shamt   = f.shamt;
  assign func    = f.func;
  assign Imm     = f.imm;
  assign Imm_abs = f.imm_abs;

endmodule
